// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg: shared types for the R32 data-side interconnect.
//   region_t  - decoded target of a core access
//   state_t   - bus FSM state
//   bus_req_t - latched core request (rw, address, wdata, strobe)
//   strobe_merge() - byte-lane merge of new write data into an old word
package soc_bus_pkg;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_TIMER,
    REGION_NONE
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAM_ACC,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [31:0] TIMER_OFFSET = 32'h100;

  typedef struct packed {
    logic        rw;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  strobe;
  } bus_req_t;

  function automatic logic [31:0] strobe_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/soc_bus_decode.sv
// soc_bus_decode: combinational address decoder.
//   address_i/rw_i/strobe_i - live core request
//   region_o - RAM, MMIO port window, timer (SOC_BUS_TIMER_EN only) or none
//   index_o  - MMIO port index ((addr-MMIO_BASE)>>2)
//   fault_o  - misaligned, unmapped, or MMIO write with no byte lanes
// Macro SOC_BUS_TIMER_EN maps the cycle timer at MMIO_BASE+TIMER_OFFSET.
module soc_bus_decode
  import soc_bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = 32'h0000_1000,
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int          NUM_PORTS = 4
) (
  input  logic [31:0] address_i,
  input  logic        rw_i,
  input  logic [3:0]  strobe_i,
  output region_t     region_o,
  output logic [3:0]  index_o,
  output logic        fault_o
);
  localparam logic [31:0] RAM_BYTES  = 32'(4 * RAM_WORDS);
  localparam logic [31:0] MMIO_BYTES = 32'(4 * NUM_PORTS);

  logic [31:0] ram_off, mmio_off;
  assign ram_off  = address_i - RAM_BASE;
  assign mmio_off = address_i - MMIO_BASE;
  assign index_o  = mmio_off[5:2];

  // Lower-bound compare guards against the subtraction wrapping around.
  always_comb begin
    region_o = REGION_NONE;
    if (address_i >= RAM_BASE && ram_off < RAM_BYTES) region_o = REGION_RAM;
    else if (address_i >= MMIO_BASE && mmio_off < MMIO_BYTES) region_o = REGION_MMIO;
`ifdef SOC_BUS_TIMER_EN
    else if (mmio_off == TIMER_OFFSET) region_o = REGION_TIMER;
`endif
  end

  assign fault_o = (address_i[1:0] != 2'b00) || (region_o == REGION_NONE) ||
                   (region_o == REGION_MMIO && rw_i && strobe_i == 4'b0000);

endmodule

// File: rtl/soc_data_bus.sv
// soc_data_bus: R32 data port to RAM / MMIO output ports interconnect.
//   i_req/i_rw/i_address/i_wdata/i_strobe - core request, held until o_ready
//   o_rdata/o_ready                       - one-cycle completion with read data
//   o_ram_*/i_ram_data                    - synchronous RAM (data one cycle after o_ram_en)
//   o_ports                               - NUM_PORTS x PORT_WIDTH output registers
//   o_error/o_fault_address               - sticky fault flag, first faulting address
// Macro SOC_BUS_TIMER_EN adds a free-running 32-bit cycle counter readable at
// MMIO_BASE+TIMER_OFFSET; without it that address faults.
module soc_data_bus
  import soc_bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE    = 32'h0000_1000,
  parameter int          RAM_WORDS   = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
  parameter int          NUM_PORTS   = 4,
  parameter int          PORT_WIDTH  = 8,
  parameter logic [31:0] PORT_RESET  = 32'h0,
  parameter int          WAIT_STATES = 0
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_req,
  input  logic                            i_rw,
  input  logic [31:0]                     i_address,
  input  logic [31:0]                     i_wdata,
  input  logic [3:0]                      i_strobe,
  output logic [31:0]                     o_rdata,
  output logic                            o_ready,
  output logic                            o_ram_en,
  output logic                            o_ram_rw,
  output logic [$clog2(RAM_WORDS)-1:0]    o_ram_address,
  output logic [31:0]                     o_ram_data,
  output logic [3:0]                      o_ram_strobe,
  input  logic [31:0]                     i_ram_data,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] o_ports,
  output logic                            o_error,
  output logic [31:0]                     o_fault_address
);
  localparam int AW = $clog2(RAM_WORDS);

  state_t   state_q, state_d;
  logic [3:0] wait_q, wait_d;
  bus_req_t ram_q;          // last RAM request; o_ram_* hold it while idle
  logic     cap_q;          // cycle after o_ram_en: RAM read data is on i_ram_data
  logic [31:0] rdata_q, acc_rdata, mmio_rd, timer_rd;
  logic     error_q;
  logic [31:0] fault_addr_q;
  logic [PORT_WIDTH-1:0] port_q [NUM_PORTS];

  region_t  dec_region;
  logic [3:0] dec_index;
  logic     dec_fault, accept, port_we;

  soc_bus_decode #(
    .RAM_BASE(RAM_BASE), .RAM_WORDS(RAM_WORDS),
    .MMIO_BASE(MMIO_BASE), .NUM_PORTS(NUM_PORTS)
  ) u_decode (
    .address_i(i_address), .rw_i(i_rw), .strobe_i(i_strobe),
    .region_o(dec_region), .index_o(dec_index), .fault_o(dec_fault)
  );

  assign accept  = (state_q == ST_IDLE) && i_req;
  assign port_we = accept && !dec_fault && dec_region == REGION_MMIO && i_rw;

`ifdef SOC_BUS_TIMER_EN
  logic [31:0] timer_q;
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) timer_q <= '0;
    else         timer_q <= timer_q + 32'd1;
  assign timer_rd = timer_q;
`else
  assign timer_rd = '0;
`endif

  // FSM: state register
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;

  // FSM: next state (and wait-state counter)
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      ST_IDLE:    if (i_req) state_d = (!dec_fault && dec_region == REGION_RAM) ? ST_RAM_ACC : ST_RESP;
      ST_RAM_ACC: begin
        state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
        wait_d  = 4'(WAIT_STATES - 1);
      end
      ST_WAIT: begin
        if (wait_q == 4'd0) state_d = ST_RESP;
        wait_d = wait_q - 4'd1;
      end
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_ram_en = (state_q == ST_RAM_ACC);
    o_ready  = (state_q == ST_RESP);
  end

  always_comb begin
    mmio_rd = '0;
    for (int k = 0; k < NUM_PORTS; k++)
      if (dec_index == 4'(k)) mmio_rd = 32'(port_q[k]);
  end

  // MMIO/timer read data is sampled at accept; faults read as zero.
  always_comb begin
    acc_rdata = '0;
    if (!dec_fault)
      case (dec_region)
        REGION_MMIO:  acc_rdata = mmio_rd;
        REGION_TIMER: acc_rdata = timer_rd;
        default:      acc_rdata = '0;
      endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wait_q       <= '0;
      ram_q        <= '0;
      cap_q        <= 1'b0;
      rdata_q      <= '0;
      error_q      <= 1'b0;
      fault_addr_q <= '0;
      for (int k = 0; k < NUM_PORTS; k++) port_q[k] <= PORT_RESET[PORT_WIDTH-1:0];
    end else begin
      wait_q <= wait_d;
      cap_q  <= (state_q == ST_RAM_ACC);
      if (cap_q && !ram_q.rw) rdata_q <= i_ram_data;
      if (accept) begin
        rdata_q <= acc_rdata;
        if (!dec_fault && dec_region == REGION_RAM)
          ram_q <= '{rw: i_rw, address: i_address, wdata: i_wdata, strobe: i_strobe};
        if (dec_fault) begin
          error_q <= 1'b1;
          if (!error_q) fault_addr_q <= i_address;
        end
      end
      // Lanes above PORT_WIDTH are dropped by the truncating cast.
      for (int k = 0; k < NUM_PORTS; k++)
        if (port_we && dec_index == 4'(k))
          port_q[k] <= PORT_WIDTH'(strobe_merge(32'(port_q[k]), i_wdata, i_strobe));
    end
  end

  // With no wait states RESP is the capture cycle itself, so forward the RAM.
  assign o_rdata = (cap_q && !ram_q.rw) ? i_ram_data : rdata_q;

  logic [31:0] ram_off_q;
  logic        unused_ram_off;
  assign ram_off_q      = ram_q.address - RAM_BASE;
  assign o_ram_address  = ram_off_q[AW+1:2];
  assign unused_ram_off = ^{ram_off_q[31:AW+2], ram_off_q[1:0]};
  assign o_ram_rw       = ram_q.rw;
  assign o_ram_data     = ram_q.wdata;
  assign o_ram_strobe   = ram_q.strobe;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    assign o_ports[k*PORT_WIDTH +: PORT_WIDTH] = port_q[k];
  end

  assign o_error         = error_q;
  assign o_fault_address = fault_addr_q;

endmodule

// File: doc/soc_data_bus.md
Name: soc_data_bus

Overview:
Parametrised data-side interconnect between the R32 core data port and the SoC memories and peripherals.
- Decodes the core byte address into three targets: a RAM window, an MMIO window of NUM_PORTS output registers, or unmapped.
- Applies configurable RAM wait states and drives a request/ready handshake back to the core.
- Generalises the single fixed hex-byte output into NUM_PORTS registered output ports with byte-strobe writes, readback and sticky fault capture.

Parameters:
- RAM_BASE, 32'h0000_1000, byte base address of the RAM window.
- RAM_WORDS, 1024, RAM depth in 32-bit words (power of two).
- MMIO_BASE, 32'h8000_0000, byte base address of the MMIO window.
- NUM_PORTS, 4, number of output ports (1..16).
- PORT_WIDTH, 8, bits per port (1..32).
- PORT_RESET, 0, reset value of every port.
- WAIT_STATES, 0, extra cycles inserted on RAM accesses (0..15).

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_req  in  1  core data request; held high until o_ready
- i_rw  in  1  1 = write, 0 = read
- i_address  in  32  byte address
- i_wdata  in  32  write data
- i_strobe  in  4  byte-lane write enables
- o_rdata  out  32  read data, valid while o_ready = 1
- o_ready  out  1  one-cycle completion pulse
- o_ram_en  out  1  RAM access enable
- o_ram_rw  out  1  RAM write
- o_ram_address  out  $clog2(RAM_WORDS)  RAM word address
- o_ram_data  out  32  RAM write data
- o_ram_strobe  out  4  RAM byte enables
- i_ram_data  in  32  RAM read data, one cycle after o_ram_en
- o_ports  out  NUM_PORTS*PORT_WIDTH  output ports; port k occupies bits [k*PORT_WIDTH +: PORT_WIDTH]
- o_error  out  1  sticky bus fault
- o_fault_address  out  32  address of the first fault

Behaviour:
- Reset (asynchronous, active-high): FSM goes to IDLE; o_ready=0; o_rdata=0; o_ram_en=0; all ports=PORT_RESET; o_error=0; o_fault_address=0. A reset during a transaction discards it and issues no o_ready.
- FSM states: IDLE, RAM_ACC, WAIT, RESP.
  - IDLE: when i_req=1, latch i_rw, i_address, i_wdata and i_strobe (accept cycle, cycle 0), then decode.
  - RAM hit: go to RAM_ACC.
  - MMIO or fault: go to RESP.
  - RAM_ACC (cycle 1): o_ram_en=1 for exactly one cycle, driven from the latched request. Go to WAIT if WAIT_STATES>0, else RESP.
  - WAIT: counter counts WAIT_STATES cycles, then go to RESP.
  - RESP: o_ready=1 for one cycle, o_rdata registered; return to IDLE.
- Latency from accept to o_ready:
  - RAM: 2+WAIT_STATES cycles. RAM read data is captured the cycle after o_ram_en.
  - MMIO and fault: 1 cycle.
- i_req is ignored outside IDLE. A new request may be accepted in the cycle after RESP.
- Decode:
  - RAM hit: RAM_BASE ≤ addr < RAM_BASE+4*RAM_WORDS; o_ram_address = (addr-RAM_BASE)>>2.
  - MMIO hit: MMIO_BASE ≤ addr < MMIO_BASE+4*NUM_PORTS; port index = (addr-MMIO_BASE)>>2.
  - Fault: addr[1:0]≠0, unmapped address, or an MMIO write with i_strobe=0.
- MMIO write: byte lanes enabled by i_strobe update the port bits that fall within PORT_WIDTH; bits above PORT_WIDTH are discarded. The update takes effect in the RESP cycle.
- MMIO read: o_rdata = port value, zero-extended.
- Fault handling:
  - A fault read returns o_rdata=0.
  - A fault write has no side effect.
  - o_error sets and stays set until reset.
  - o_fault_address captures only the first fault.
- o_ram_* outputs other than o_ram_en hold their last value when idle.

Optional Feature:
SOC_BUS_TIMER_EN
- Defined: adds a free-running 32-bit cycle counter, reset to 0, wrapping at 2^32-1 → 0.
  - Readable at MMIO_BASE+32'h100; the read returns the value sampled in the accept cycle.
  - Writes to that address are ignored and are not faults.
- Undefined: MMIO_BASE+32'h100 decodes as unmapped and faults.

Decomposition:
- Shared package soc_bus_pkg holds:
  - region enum: REGION_RAM, REGION_MMIO, REGION_TIMER, REGION_NONE;
  - FSM state enum;
  - TIMER_OFFSET = 32'h100;
  - the bus request struct (rw, address, wdata, strobe).
- Sub-module soc_bus_decode: purely combinational; maps address, rw and strobe to region, index and fault. Instantiated once.

Test Plan:
- WAIT_STATES=2: write 32'hDEADBEEF to 32'h1004 with strobe 4'hF, then read it back → o_ram_en pulses with o_ram_address=1; each o_ready arrives 4 cycles after accept; read returns 32'hDEADBEEF.
- Write 32'h0000_00A5 to 32'h8000_0008 with strobe 4'b0001 → port 2 = 8'hA5, other ports 0; a read of the same address returns 32'h0000_00A5 with o_ready at cycle 1.
- Read 32'h8000_0003 (misaligned), then read 32'h4000_0000 → o_rdata=0; o_error=1; o_fault_address=32'h8000_0003 and unchanged after the second fault.
- Assert i_reset one cycle after accepting a RAM read with WAIT_STATES=3 → no o_ready; ports=PORT_RESET; o_error=0; a new request completes normally after reset.
- i_req held high across back-to-back MMIO writes → exactly one o_ready per transaction; no double write.
- With SOC_BUS_TIMER_EN: two reads of 32'h8000_0100 accepted 5 cycles apart → values differ by 5. Without the macro, the same read faults.
